// File: rtl/obi_pkg.sv
// OBI bus request/response structures shared by the memory nodes.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/strela_pkg.sv
// Shared constants and types for the STRELA CGRA memory nodes.
package strela_pkg;

  localparam int unsigned MEM_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MREQ,
    S_DRAIN,
    S_DONE
  } omn_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Registered-output FIFO (no fall-through) with synchronous flush.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0] FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  do_push, do_pop;

  // Status flags and guarded push/pop strobes.
  always_comb begin
    full_o  = (cnt_q == FULL_CNT);
    empty_o = (cnt_q == '0);
    usage_o = cnt_q[ADDR_DEPTH-1:0];
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    data_o  = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents need no reset since the count gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/output_memory_node.sv
// Output memory node: drains ODM result words through a FIFO into OBI writes
// and raises done_o once every issued write has been acknowledged.
module output_memory_node
  import strela_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = MEM_MAX_OUTSTANDING
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        exec_i,
  input  logic [31:0] output_addr_i,
  input  logic [15:0] output_size_i,
  input  logic [15:0] output_stride_i,
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  input  logic [31:0] din_i,
  input  logic        din_v_i,
  output logic        din_r_o,
  output logic        done_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam int unsigned FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  omn_state_e    state_q;
  logic [15:0]   addr_offset_q;
  logic [OW-1:0] outstanding_q, outstanding_d;

  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [FAW-1:0] fifo_usage_unused;
  logic [31:0]   rdata_unused;
  logic          req, txn, push, rsp_accept;
  logic [16:0]   next_offset;

  assign rdata_unused = masters_resp_i.rdata;

  // Handshakes, 17-bit offset step and outstanding-count next value.
  always_comb begin
    din_r_o     = (state_q == S_MREQ) && !fifo_full;
    req         = (state_q == S_MREQ) && !fifo_empty && (outstanding_q < MAX_OUT);
    txn         = req && masters_resp_i.gnt;
    push        = din_v_i && din_r_o;
    rsp_accept  = masters_resp_i.rvalid && (outstanding_q != '0);
    next_offset = {1'b0, addr_offset_q} + {1'b0, output_stride_i};
    case ({txn, rsp_accept})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    done_o = (state_q == S_DONE);
  end

  // OBI write request built from the registered FIFO head and offset.
  always_comb begin
    masters_req_o       = '0;
    masters_req_o.req   = req;
    masters_req_o.we    = 1'b1;
    masters_req_o.be    = 4'b1111;
    masters_req_o.addr  = output_addr_i + {16'h0, addr_offset_q};
    masters_req_o.wdata = fifo_head;
  end

  // Control FSM with offset and outstanding-response tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_offset_q <= '0;
      outstanding_q <= '0;
    end else if (clr_i) begin
      state_q       <= S_IDLE;
      addr_offset_q <= '0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      case (state_q)
        S_IDLE: begin
          if (exec_i) state_q <= (output_size_i != '0) ? S_MREQ : S_DONE;
        end
        S_MREQ: begin
          if (txn) begin
            addr_offset_q <= next_offset[15:0];
            if (next_offset >= {1'b0, output_size_i}) state_q <= S_DRAIN;
          end
        end
        // Looks at the next count so the final rvalid cycle already exits.
        S_DRAIN: begin
          if (outstanding_d == '0) state_q <= S_DONE;
        end
        default: state_q <= S_DONE;
      endcase
    end
  end

  fifo_v3 #(
    .DATA_WIDTH(32),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (!rst_i),
    .flush_i(clr_i),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .usage_o(fifo_usage_unused),
    .data_i (din_i),
    .push_i (push),
    .data_o (fifo_head),
    .pop_i  (txn)
  );

endmodule
